ysyx_23060111_fetch_unit: RTL
=============================

// Module: ysyx_23060111_fetch_unit
// PURPOSE
//  Multi-cycle instruction fetch stage between the PC register and the decoder.
//  Accepts a PC, issues one word read on a req/gnt/rvalid instruction-memory port and
//  presents the instruction to IDU with a valid/ready handshake.
//  Tolerates variable memory latency and supports flush on redirect.
//  Reports misaligned, bus-error and timeout faults.
// PARAMETERS
//  TIMEOUT    255  max cycles in WAIT/DRAIN before rvalid; 1..2^TO_W-1
//  TO_W       8    width of timeout counter
//  FAULT_INST 32'h00000013  instruction driven on inst_out when fault_code!=0 (NOP)
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  pc_in       in   32  fetch address from PC register
//  pc_valid    in   1   pc_in valid
//  fetch_ready out  1   1 only in IDLE; pc accepted when pc_valid&fetch_ready
//  flush       in   1   redirect: abandon current fetch
//  mem_req     out  1   read request, held until mem_gnt
//  mem_addr    out  32  request word address (= latched pc)
//  mem_gnt     in   1   request accepted this cycle
//  mem_rvalid  in   1   read data valid; never in the same cycle as its mem_gnt
//  mem_rdata   in   32  read data
//  mem_err     in   1   bus error, qualified by mem_rvalid
//  inst_valid  out  1   instruction to IDU valid
//  inst_ready  in   1   IDU accepts
//  inst_out    out  32  instruction word
//  inst_pc     out  32  pc of inst_out
//  fault_code  out  2   00 ok, 01 misaligned, 10 bus error, 11 timeout
// BEHAVIOUR
//  - Reset: state IDLE; mem_req=0, inst_valid=0, fault_code=0, mem_addr=0,
//    inst_out=0, inst_pc=0, counter=0. Reset mid-fetch drops everything; a late
//    mem_rvalid arriving in IDLE is ignored.
//  - States: IDLE, REQ, WAIT, OUT, DRAIN. All outputs registered or state-decoded.
//  - IDLE: fetch_ready=1. On pc_valid (no flush): latch pc. pc_in[1:0]!=0 -> OUT
//    with fault 01, inst_out=FAULT_INST, no memory access; else -> REQ.
//  - REQ: mem_req=1, mem_addr=pc_q, stable until mem_gnt. On mem_gnt -> WAIT,
//    counter cleared.
//  - WAIT: counter++ per cycle. mem_rvalid: capture rdata; mem_err -> fault 10 and
//    inst_out=FAULT_INST; -> OUT. Counter reaching TIMEOUT without rvalid -> OUT,
//    fault 11, inst_out=FAULT_INST.
//  - OUT: inst_valid=1; inst_out/inst_pc/fault_code stable until inst_ready.
//    inst_ready -> IDLE (inst_valid low next cycle).
//  - Latency: pc accepted cycle T; mem_req at T+1; gnt at T+1, rvalid at T+2 ->
//    inst_valid at T+3. Throughput max 1 instruction per 4 cycles.
//  - Flush (priority over every other event in the same cycle):
//    IDLE: pc_valid ignored, stay IDLE. REQ: drop mem_req next cycle -> IDLE, even if
//    mem_gnt same cycle (then -> DRAIN instead). WAIT: -> DRAIN. OUT: -> IDLE,
//    instruction discarded even if inst_ready same cycle. DRAIN: no effect.
//  - DRAIN: fetch_ready=0, inst_valid=0; wait for mem_rvalid (discarded) or timeout,
//    then IDLE. Guarantees no stale response is matched to a later request.
//  - Counter saturates at TIMEOUT; no wrap. pc_q wraps naturally (no arithmetic).
// TESTING
//  - Basic: pc 0x80000000, gnt immediate, rvalid 1 cycle later rdata 0x00100093,
//    inst_ready=1 -> inst_valid at T+3, inst_out 0x00100093, inst_pc 0x80000000, fault 00.
//  - Backpressure/stall: gnt delayed 3 cycles, inst_ready low 5 cycles -> mem_req/mem_addr
//    and inst_out/inst_pc stable throughout; exactly one handshake, fetch_ready only in IDLE.
//  - Faults: pc 0x80000002 -> fault 01, no mem_req ever; rvalid with mem_err -> fault 10,
//    inst_out 0x00000013; no rvalid for 255 cycles -> fault 11.
//  - Flush in WAIT: flush 1 cycle after gnt, rvalid 4 cycles later -> no inst_valid; next
//    pc 0x80000010 issues mem_req only after drained rvalid; its data returned correctly.
//  - Flush+gnt same cycle in REQ -> DRAIN; flush+inst_ready in OUT -> discarded, IDLE.
//  - Reset asserted in WAIT -> all outputs at reset values next cycle; late rvalid ignored.

Source files
------------

// File: rtl/ysyx_23060111_fetch_unit_if.sv
// Fetch-unit port bundle. It carries the PC request from the PC register, the
// instruction-memory request/response and the instruction handoff to IDU.
// The master modport is the fetch unit. The slave modport is its environment.
interface ysyx_23060111_fetch_unit_if;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        fetch_ready;
    logic        flush;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [1:0]  fault_code;

    modport master (
        input  pc_in, pc_valid, flush,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
        input  inst_ready,
        output fetch_ready, mem_req, mem_addr,
        output inst_valid, inst_out, inst_pc, fault_code
    );

    modport slave (
        output pc_in, pc_valid, flush,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err,
        output inst_ready,
        input  fetch_ready, mem_req, mem_addr,
        input  inst_valid, inst_out, inst_pc, fault_code
    );
endinterface

// File: rtl/ysyx_23060111_fetch_unit.sv
// Multi-cycle instruction fetch stage. The unit takes one PC and issues one word
// read on a req/gnt/rvalid port. It then hands the instruction to IDU with a
// valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a new pc
// REQ   | mem_req held until granted
// WAIT  | granted, waiting for rvalid (timeout counter running)
// OUT   | instruction/fault presented to IDU
// DRAIN | abandoned fetch, swallowing its response (or timing out)
module ysyx_23060111_fetch_unit #(
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned TO_W       = 8,
    parameter logic [31:0] FAULT_INST = 32'h00000013
) (
    input logic                        clk,
    input logic                        rst,
    ysyx_23060111_fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [1:0]      fault_q, fault_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0] cnt_inc;
    logic            to_hit;

    // The counter saturates and never wraps back to zero.
    assign cnt_inc = (cnt_q == TO_MAX) ? cnt_q : cnt_q + TO_W'(1);
    assign to_hit  = (cnt_inc == TO_MAX);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            fault_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. Flush is evaluated before every other event.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.flush && bus.pc_valid)
                    state_d = (bus.pc_in[1:0] != 2'b00) ? S_OUT : S_REQ;
            end
            S_REQ: begin
                if (bus.flush)
                    state_d = bus.mem_gnt ? S_DRAIN : S_IDLE;
                else if (bus.mem_gnt)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                // If the response lands in the same cycle as the flush, it is
                // discarded here. No stale response then remains to drain.
                if (bus.flush)
                    state_d = bus.mem_rvalid ? S_IDLE : S_DRAIN;
                else if (bus.mem_rvalid || to_hit)
                    state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.flush || bus.inst_ready)
                    state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (bus.mem_rvalid || to_hit)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates: latch pc, capture data or fault, run the timeout counter.
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.flush && bus.pc_valid) begin
                    pc_d  = bus.pc_in;
                    cnt_d = '0;
                    if (bus.pc_in[1:0] != 2'b00) begin
                        fault_d = 2'b01;
                        inst_d  = FAULT_INST;
                    end else begin
                        fault_d = 2'b00;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_gnt)
                    cnt_d = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (!bus.flush) begin
                    if (bus.mem_rvalid) begin
                        if (bus.mem_err) begin
                            fault_d = 2'b10;
                            inst_d  = FAULT_INST;
                        end else begin
                            fault_d = 2'b00;
                            inst_d  = bus.mem_rdata;
                        end
                    end else if (to_hit) begin
                        fault_d = 2'b11;
                        inst_d  = FAULT_INST;
                    end
                end
            end
            S_DRAIN: cnt_d = cnt_inc;
            default: ;
        endcase
    end

    // Outputs are either decoded from the state or taken directly from registers.
    always_comb begin
        bus.fetch_ready = (state_q == S_IDLE);
        bus.mem_req     = (state_q == S_REQ);
        bus.inst_valid  = (state_q == S_OUT);
        bus.mem_addr    = pc_q;
        bus.inst_pc     = pc_q;
        bus.inst_out    = inst_q;
        bus.fault_code  = fault_q;
    end

endmodule
